// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_arbiter_if : producer / arbiter / UART TX core handshake bundle
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ack;
  logic [NUM_REQ-1:0]   grant;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 arb_busy;

  modport master (
    output req, req_data, req_last, tx_busy,
    input  req_ack, grant, tx_start, tx_data, arb_busy
  );

  modport slave (
    input  req, req_data, req_last, tx_busy,
    output req_ack, grant, tx_start, tx_data, arb_busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_arbiter : packet-granular round-robin sharing of one UART transmitter
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int STALL_MAX = 1024,
  parameter int BUSY_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STL_W = $clog2(STALL_MAX + 1);
  localparam int BSY_W = $clog2(BUSY_WAIT + 1);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t             state_q,    state_d;
  logic [NUM_REQ-1:0] grant_q,    grant_d;
  logic [IDX_W-1:0]   owner_q,    owner_d;
  logic [NUM_REQ-1:0] req_ack_q,  req_ack_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q,  tx_data_d;
  logic               arb_busy_q, arb_busy_d;
  logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [STL_W-1:0]   stall_q,    stall_d;
  logic [BSY_W-1:0]   busy_cnt_q, busy_cnt_d;
  logic               last_q,     last_d;

  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W:0]     cand;
  logic [IDX_W-1:0]   next_ptr;

  // First requester at or after rr_ptr, wrapping from NUM_REQ-1 back to 0.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!pick_vld && bus.req[cand[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IDX_W-1:0];
      end
    end
  end

  assign next_ptr = (owner_q == C_LAST_IDX) ? '0 : owner_q + IDX_W'(1);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    req_ack_d  = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    arb_busy_d = arb_busy_q;
    rr_ptr_d   = rr_ptr_q;
    stall_d    = stall_q;
    busy_cnt_d = busy_cnt_q;
    last_d     = last_q;

    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d    = NUM_REQ'(1) << pick_idx;
          owner_d    = pick_idx;
          arb_busy_d = 1'b1;
          stall_d    = '0;
          state_d    = LOAD;
        end
      end

      LOAD: begin
        // A busy TX core freezes both loading and stall accounting.
        if (!bus.tx_busy) begin
          if (bus.req[owner_q]) begin
            tx_data_d         = bus.req_data[{owner_q, 3'b000} +: 8];
            tx_start_d        = 1'b1;
            req_ack_d[owner_q] = 1'b1;
            last_d            = bus.req_last[owner_q];
            stall_d           = '0;
            busy_cnt_d        = '0;
            state_d           = WAIT_BUSY;
          end else if (stall_q == STL_W'(STALL_MAX - 1)) begin
            grant_d    = '0;
            arb_busy_d = 1'b0;
            rr_ptr_d   = next_ptr;
            stall_d    = '0;
            state_d    = IDLE;
          end else begin
            stall_d = stall_q + STL_W'(1);
          end
        end
      end

      WAIT_BUSY: begin
        if (bus.tx_busy || (busy_cnt_q == BSY_W'(BUSY_WAIT - 1))) begin
          busy_cnt_d = '0;
          state_d    = WAIT_DONE;
        end else begin
          busy_cnt_d = busy_cnt_q + BSY_W'(1);
        end
      end

      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (last_q) begin
            grant_d    = '0;
            arb_busy_d = 1'b0;
            rr_ptr_d   = next_ptr;
            state_d    = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      req_ack_q  <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      arb_busy_q <= 1'b0;
      rr_ptr_q   <= '0;
      stall_q    <= '0;
      busy_cnt_q <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      req_ack_q  <= req_ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      arb_busy_q <= arb_busy_d;
      rr_ptr_q   <= rr_ptr_d;
      stall_q    <= stall_d;
      busy_cnt_q <= busy_cnt_d;
      last_q     <= last_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.req_ack  = req_ack_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.arb_busy = arb_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter : producer queues + UART busy model driving uart_tx_arbiter
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N         = 3;
  localparam int STALL_MAX = 32;
  localparam int BUSY_WAIT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ  (N),
    .STALL_MAX(STALL_MAX),
    .BUSY_WAIT(BUSY_WAIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef logic [7:0] byteq_t [$];

  byteq_t     pq [N];
  bit         hold [N];
  bit         stall_arm [N];
  int         n_sent [N];
  int         svc [$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         fbusy = 10;
  int         busy_rem = 0;
  int         model_owner = -1;
  int         model_rr = 0;
  int         release_due = -1;
  int         start_due = -1;
  int         keep_due = -1;
  int         keep_mask = 0;
  bit         last_done = 1'b0;
  bit         pkt_acked = 1'b0;
  logic [7:0] exp_txd = 8'h00;
  logic [N-1:0] prev_grant = '0;
  logic       prev_tx_start = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int queued();
    int s = 0;
    for (int i = 0; i < N; i++) s += pq[i].size();
    return s;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req[i]             = (pq[i].size() > 0) && !hold[i];
      bus.req_last[i]        = (pq[i].size() == 1);
      bus.req_data[i*8 +: 8] = (pq[i].size() > 0) ? pq[i][0] : 8'h00;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      pq[i].delete();
      hold[i]      = 1'b0;
      stall_arm[i] = 1'b0;
    end
    model_owner   = -1;
    model_rr      = 0;
    exp_txd       = 8'h00;
    release_due   = -1;
    start_due     = -1;
    keep_due      = -1;
    last_done     = 1'b0;
    pkt_acked     = 1'b0;
    prev_grant    = '0;
    prev_tx_start = 1'b0;
    drive();
  endtask

  task automatic step();
    logic [N-1:0] req_seen;
    logic         busy_seen;
    logic         busy_now;
    logic [7:0]   dropped;
    int           o;
    req_seen  = bus.req;
    busy_seen = bus.tx_busy;
    @(posedge clk);
    #1;
    cyc++;

    chk("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
    chk("arb_busy", 32'(bus.arb_busy), 32'(|bus.grant));
    if (rst_n && prev_grant == '0 && req_seen != '0)
      chk("idle_grant", 32'(bus.grant != '0), 32'd1);
    if (cyc == release_due) chk("release_time", 32'(bus.grant), 32'd0);
    if (cyc == keep_due)    chk("stall_hold", 32'(bus.grant), 32'(keep_mask));
    if (cyc == start_due)   chk("next_start", 32'(bus.tx_start), 32'd1);

    // Packet ownership as the round-robin rule dictates.
    if (model_owner < 0 && bus.grant != '0) begin
      o = rr_pick(req_seen, model_rr);
      chk("rr_pick", 32'(bus.grant), (o < 0) ? 32'd0 : 32'(1 << o));
      model_owner = o;
      last_done   = 1'b0;
      pkt_acked   = 1'b0;
      if (o >= 0) svc.push_back(o);
    end else if (model_owner >= 0 && bus.grant == '0) begin
      chk("release_ok", 32'((pq[model_owner].size() == 0) || hold[model_owner]), 32'd1);
      if (hold[model_owner]) begin
        pq[model_owner].delete();
        hold[model_owner]      = 1'b0;
        stall_arm[model_owner] = 1'b0;
      end
      model_rr    = (model_owner + 1) % N;
      model_owner = -1;
    end else if (model_owner >= 0) begin
      chk("grant_owner", 32'(bus.grant), 32'(1 << model_owner));
    end

    if (bus.tx_start || bus.req_ack != '0) begin
      chk("start_width", 32'({bus.tx_start, prev_tx_start}), 32'b10);
      if (model_owner >= 0 && pq[model_owner].size() > 0) begin
        o = model_owner;
        chk("ack_owner", 32'(bus.req_ack), 32'(1 << o));
        chk("ack_while_held", 32'(hold[o]), 32'd0);
        chk("tx_data", 32'(bus.tx_data), 32'(pq[o][0]));
        exp_txd   = pq[o][0];
        dropped   = pq[o].pop_front();
        n_sent[o]++;
        last_done = (pq[o].size() == 0);
        pkt_acked = 1'b1;
        if (stall_arm[o]) hold[o] = 1'b1;
        if (fbusy == 0) begin
          if (last_done) release_due = cyc + BUSY_WAIT + 1;
          else           start_due   = cyc + BUSY_WAIT + 2;
        end
      end else begin
        chk("ack_unexpected", 32'(bus.req_ack), 32'd0);
      end
    end else begin
      chk("tx_data_hold", 32'(bus.tx_data), 32'(exp_txd));
    end

    // UART TX core model: busy for fbusy cycles after each start pulse.
    if (bus.tx_start) busy_rem = fbusy;
    else if (busy_rem > 0) busy_rem--;
    busy_now    = (busy_rem > 0);
    bus.tx_busy = busy_now;
    if (busy_seen && !busy_now && model_owner >= 0 && pkt_acked) begin
      if (last_done) begin
        release_due = cyc + 1;
      end else if (hold[model_owner]) begin
        keep_due    = cyc + STALL_MAX;
        keep_mask   = 1 << model_owner;
        release_due = cyc + STALL_MAX + 1;
      end else begin
        start_due = cyc + 2;
      end
    end

    prev_grant    = bus.grant;
    prev_tx_start = bus.tx_start;
    drive();
  endtask

  task automatic drain(input int budget);
    for (int t = 0; t < budget; t++) begin
      if (queued() == 0 && bus.grant == '0 && busy_rem == 0) break;
      step();
    end
    chk("drain_bytes", 32'(queued()), 32'd0);
    chk("drain_grant", 32'(bus.grant), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic clear_sent();
    for (int i = 0; i < N; i++) n_sent[i] = 0;
    svc.delete();
  endtask

  initial begin
    bus.tx_busy = 1'b0;
    model_reset();
    clear_sent();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant",    32'(bus.grant),    32'd0);
    chk("rst_req_ack",  32'(bus.req_ack),  32'd0);
    chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst_tx_data",  32'(bus.tx_data),  32'd0);
    chk("rst_arb_busy", 32'(bus.arb_busy), 32'd0);
    rst_n = 1'b1;
    step();

    // Single requester, "12 ".
    fbusy = 10;
    clear_sent();
    pq[0].push_back(8'h31);
    pq[0].push_back(8'h32);
    pq[0].push_back(8'h20);
    drive();
    drain(300);
    chk("single_count", 32'(n_sent[0]), 32'd3);

    // Contention from reset: 0 and 2 raised together.
    do_reset();
    fbusy = 3;
    clear_sent();
    for (int b = 0; b < 2; b++) begin
      pq[0].push_back(8'($urandom));
      pq[2].push_back(8'($urandom));
    end
    drive();
    drain(300);
    chk("cont_npkts", 32'(svc.size()), 32'd2);
    if (svc.size() == 2) begin
      chk("cont_first",  32'(svc[0]), 32'd0);
      chk("cont_second", 32'(svc[1]), 32'd2);
    end

    // Wrap: after requester 2, requesters 0 and 1 together -> 0 first.
    clear_sent();
    pq[0].push_back(8'hA0);
    pq[1].push_back(8'hB1);
    drive();
    drain(200);
    if (svc.size() > 0) chk("wrap_first", 32'(svc[0]), 32'd0);
    else                chk("wrap_npkts", 32'(svc.size()), 32'd2);

    // Stall: requester 0 drops req after its first byte; 1 waits.
    fbusy = 5;
    clear_sent();
    stall_arm[0] = 1'b1;
    pq[0].push_back(8'h41);
    pq[0].push_back(8'h42);
    pq[0].push_back(8'h43);
    drive();
    step();
    step();
    step();
    pq[1].push_back(8'h51);
    pq[1].push_back(8'h52);
    drive();
    drain(600);
    chk("stall_sent0", 32'(n_sent[0]), 32'd1);
    chk("stall_sent1", 32'(n_sent[1]), 32'd2);
    if (svc.size() == 2) chk("stall_next", 32'(svc[1]), 32'd1);
    else                 chk("stall_npkts", 32'(svc.size()), 32'd2);

    // Busy guard: TX core never raises busy.
    fbusy = 0;
    clear_sent();
    for (int b = 0; b < 3; b++) pq[2].push_back(8'($urandom));
    drive();
    drain(200);
    chk("guard_sent", 32'(n_sent[2]), 32'd3);

    // Asynchronous reset while waiting for the frame to finish.
    fbusy = 10;
    clear_sent();
    for (int b = 0; b < 3; b++) pq[1].push_back(8'($urandom));
    drive();
    for (int t = 0; t < 20 && !bus.tx_start; t++) step();
    chk("mid_saw_start", 32'(bus.tx_start), 32'd1);
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_grant",    32'(bus.grant),    32'd0);
    chk("mid_rst_req_ack",  32'(bus.req_ack),  32'd0);
    chk("mid_rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("mid_rst_tx_data",  32'(bus.tx_data),  32'd0);
    chk("mid_rst_arb_busy", 32'(bus.arb_busy), 32'd0);
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    clear_sent();
    pq[1].push_back(8'h61);
    pq[2].push_back(8'h62);
    drive();
    drain(300);
    if (svc.size() > 0) chk("post_rst_first", 32'(svc[0]), 32'd1);
    else                chk("post_rst_npkts", 32'(svc.size()), 32'd2);

    // Randomised packets and TX frame lengths.
    for (int r = 0; r < 20; r++) begin
      int fsel;
      fsel  = $urandom_range(0, 4);
      fbusy = (fsel == 0) ? 0 : (fsel == 1) ? 1 : (fsel == 2) ? 2 : (fsel == 3) ? 5 : 10;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) != 0 || i == r % N) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) pq[i].push_back(8'($urandom));
          drive();
          if ($urandom_range(0, 1) != 0) step();
        end
      end
      drain(2000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
